// File: rtl/cs_series.sv
// cs_series: series-approximation filter over a 9-sample sliding window.
// Optional OUT_REG_EN registers Y (one extra cycle of latency).
module cs_series #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] X,
    output logic [DATA_W+1:0] Y
);

    localparam int N     = 9;
    localparam int SUM_W = DATA_W + 4;
    localparam int T_W   = DATA_W + 5;

    logic [DATA_W-1:0] w [N];
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] xavg;
    logic [DATA_W-1:0] xappr;
    logic [T_W-1:0]    t;
    logic [DATA_W+1:0] y_next;

    // Window shift register; W[0] holds the newest sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                w[i] <= '0;
            end
        end else begin
            w[0] <= X;
            for (int i = 1; i < N; i++) begin
                w[i] <= w[i-1];
            end
        end
    end

    // Window sum and exact floor average.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + SUM_W'(w[i]);
        end
        xavg = DATA_W'(sum / SUM_W'(N));
    end

    // Largest window sample not above the average; min(W) always qualifies.
    always_comb begin
        xappr = '0;
        for (int i = 0; i < N; i++) begin
            if (w[i] <= xavg && w[i] > xappr) begin
                xappr = w[i];
            end
        end
    end

    // Series result: (sum + 9*Xappr) / 8, truncated.
    always_comb begin
        t      = T_W'(sum) + T_W'(N) * T_W'(xappr);
        y_next = (DATA_W + 2)'(t >> 3);
    end

`ifdef OUT_REG_EN
    logic [DATA_W+1:0] y_q;

    // Output register breaks the long combinational path to the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q <= '0;
        end else begin
            y_q <= y_next;
        end
    end

    assign Y = y_q;
`else
    assign Y = y_next;
`endif

endmodule

// File: tb/tb_cs_series.sv
// tb_cs_series: scoreboard bench for cs_series.
// Directed vectors plus a random stream with a mid-stream reset.
module tb_cs_series;

    logic       clk;
    logic       reset;
    logic [7:0] X;
    logic [9:0] Y;

`ifdef OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int win [9];
    logic [9:0] sb [$];

    cs_series #(.DATA_W(8)) dut (
        .clk  (clk),
        .reset(reset),
        .X    (X),
        .Y    (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9:0] got,
                       input logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] model();
        int s, a, p;
        s = 0;
        for (int i = 0; i < 9; i++) s += win[i];
        a = s / 9;
        p = 0;
        for (int i = 0; i < 9; i++)
            if (win[i] <= a && win[i] > p) p = win[i];
        return 10'((s + 9 * p) >> 3);
    endfunction

    // expv < 0: expectation comes from the reference model
    task automatic step(input logic [7:0] x, input logic rst,
                        input int expv, input string tag);
        logic [9:0] e;
        X     = x;
        reset = rst;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 9; i++) win[i] = 0;
            sb.delete();
            if (LAT == 1) sb.push_back(10'd0);
        end else begin
            for (int i = 8; i > 0; i--) win[i] = win[i-1];
            win[0] = int'(x);
        end
        e = (expv < 0) ? model() : 10'(expv);
        sb.push_back(e);
        #1;
        if (sb.size() > LAT) chk(tag, Y, sb.pop_front());
    endtask

    initial begin
        X     = 8'h55;
        reset = 1'b1;
        for (int i = 0; i < 9; i++) win[i] = 0;

        step(8'h55, 1'b1, 0, "reset1");
        step(8'h55, 1'b1, 0, "reset2");

        for (int i = 0; i < 9; i++)
            step(8'd10, 1'b0, (i == 8) ? 22 : -1, "flat10");

        for (int i = 1; i <= 9; i++)
            step(8'(i), 1'b0, (i == 9) ? 11 : -1, "ramp");
        step(8'd20, 1'b0, 15, "ramp20");

        for (int i = 0; i < 9; i++)
            step(8'd255, 1'b0, (i == 8) ? 573 : -1, "max255");

        step(8'd0, 1'b1, 0, "reset3");
        step(8'd90, 1'b0, 11, "single90");

        step(8'd0, 1'b1, 0, "reset4");
        step(8'd255, 1'b0, 31, "outlier");
        for (int i = 0; i < 8; i++)
            step(8'd0, 1'b0, -1, "outlier_tail");

        for (int i = 0; i < 2000; i++) begin
            if (i == 1000)
                step(8'($urandom_range(0, 255)), 1'b1, 0, "rand_reset");
            else
                step(8'($urandom_range(0, 255)), 1'b0, -1, "rand");
        end

        step(8'd7, 1'b0, -1, "flush");
        step(8'd7, 1'b0, -1, "flush");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cs_series.md
Name: cs_series

Overview:
- Series-approximation filter over a sliding window of the 9 most recent 8-bit samples X.
- Per window:
  - Xavg = floor(sum/9).
  - Xappr = largest window sample not greater than Xavg.
  - Output Y = floor((sum + 9*Xappr)/8).
- Streaming datapath block: one sample in per clock, one result per clock.

Parameters:
- DATA_W, 8, sample width. Y width is DATA_W+2. Window length is fixed at 9 and is not a parameter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears the window.
- X  input  8  input sample; sampled on every rising clk edge while reset is low.
- Y  output  10  filter result for the current window contents.

Behaviour:
- State is a 9-entry shift register W[0..8], 8 bits each. W[0] is the newest sample.
- Rising clk with reset=1: all W entries become 0, so Y = 0 from then on. Reset has priority over sampling, and X is ignored while reset is high.
- Rising clk with reset=0: W[i] <= W[i-1] for i=8..1, and W[0] <= X. The oldest sample is dropped.
- Y is a purely combinational function of W; there is no combinational path from X to Y.
  - Latency: X captured at edge k gives a valid Y shortly after edge k.
  - The consumer samples Y at edge k+1.
  - Y must settle within one clock period minus 0.5 ns of setup margin.
  - Y must remain stable for 0.5 ns after each edge (hold).
- Arithmetic, all unsigned:
  - sum = W[0]+...+W[8], 12 bits, max 2295.
  - Xavg = floor(sum/9), 8 bits. Exact integer division is required; no approximation.
  - Xappr = max over i of W[i] with W[i] <= Xavg. A candidate always exists, because min(W) <= Xavg. Ties and duplicates are irrelevant, since the value is unique.
  - t = sum + 9*Xappr, 13 bits, max 4590.
  - Y = t >> 3, truncated; max 573.
- Warm-up: before 9 samples have been taken since reset, the zero-filled entries take part in the computation like real samples. There is no valid flag; the consumer discards the first 8 results.
- Reset mid-stream: the window is fully cleared at that edge, and warm-up restarts once reset falls.
- No overflow or saturation is possible at the stated widths.

Optional Feature:
- Macro OUT_REG_EN.
- Defined:
  - Y is driven from a 10-bit register loaded every rising edge with the combinational result; the register is cleared to 0 by reset.
  - Adds one cycle of latency: the result for the window updated at edge k appears after edge k+1.
  - Relaxes the output setup constraint.
- Undefined (default): Y is combinational from the window registers, as in Behaviour.

Test Plan:
- Assert reset for 2 cycles with X=0x55 -> Y=0 after the first reset edge; the window is all zero.
- After reset, feed 9 samples of 10 -> after the 9th capture, sum=90, Xavg=10, Xappr=10, Y=22 (0x016).
- Feed 1,2,...,9 -> sum=45, Xavg=5, Xappr=5, Y=11 (0x00B). Then feed 20, so the window becomes 2..9,20 -> sum=64, Xavg=7, Xappr=7, Y=15 (0x00F).
- Feed 9 samples of 255 -> sum=2295, Xappr=255, Y=573 (0x23D), the maximum value with no overflow.
- Check partial windows and outlier rejection:
  - After reset, a single sample 90 -> sum=90, Xavg=10, Xappr=0, Y=11 (0x00B).
  - Eight 0s and one 255 -> sum=255, Xavg=28, Xappr=0, Y=31 (0x01F).
- Random 2000-sample stream with a reset pulse mid-stream -> Y matches a bit-exact reference model every cycle, and Y=0 immediately after the reset edge. With OUT_REG_EN defined, all expected values shift by one cycle.
